wb_psram_responder: RTL and testbench
=====================================

// Module: wb_psram_responder
// PURPOSE
//   Wishbone B3 classic responder bridging the 16-bit CPU bus to the board's external asynchronous PSRAM.
//   Accepts word and byte-lane reads/writes, generates CE/OE/WE/UB/LB strobes with programmable wait and
//   recovery cycles, and returns exactly one registered ACK per accepted cycle. Sits between the CPU
//   master (adr[15:1], sel[1:0], stb tied to cyc) and the FPGA pins; the DQ tristate lives at top level.
// PARAMETERS
//   WAIT_CYCLES  4      cycles strobes held active per access (>=1); 4 @50 MHz covers 70 ns PSRAM
//   RECOVERY     1      idle cycles with CE_n high between accesses (0 = none)
//   BANK         8'h00  constant upper RAM address bits, ram_adr_o[23:16]
// PORTS
//   clk_i       in   1   system clock; all logic on rising edge
//   res_i       in   1   reset, synchronous, active-high
//   cyc_i       in   1   Wishbone cycle
//   stb_i       in   1   Wishbone strobe
//   we_i        in   1   1 = write
//   sel_i       in   2   byte lanes; sel_i[1] = dat[15:8], sel_i[0] = dat[7:0]
//   adr_i       in   15  word address [15:1]
//   dat_i       in   16  write data
//   ack_o       out  1   cycle acknowledge
//   dat_o       out  16  read data, registered
//   ram_adr_o   out  23  RAM word address [23:1] = {BANK, latched adr}
//   ram_dq_i    in   16  RAM data from pads
//   ram_dq_o    out  16  RAM data to pads
//   ram_dq_oe   out  1   1 = FPGA drives DQ
//   ram_ce_n    out  1   chip enable, active-low
//   ram_oe_n    out  1   output enable, active-low
//   ram_we_n    out  1   write enable, active-low
//   ram_ub_n    out  1   upper byte enable, active-low
//   ram_lb_n    out  1   lower byte enable, active-low
// BEHAVIOUR
//   Reset: state IDLE; ack_o=0, dat_o=0, ram_adr_o=0, ram_dq_o=0, ram_dq_oe=0, all *_n=1. Reset takes
//     effect at the next edge from any state; an in-flight access is abandoned (write may be truncated).
//   States: IDLE, ACCESS, ACK, RECOVER. wait counter sized for WAIT_CYCLES.
//   IDLE: if cyc_i & stb_i: latch adr_i, dat_i, sel_i, we_i. sel_i==0 -> ACK directly (no RAM activity,
//     dat_o<=0). Else -> ACCESS with counter=WAIT_CYCLES-1.
//   ACCESS: ram_ce_n=0; read: ram_oe_n=0; write: ram_we_n=0, ram_dq_oe=1, ram_dq_o=latched dat;
//     ram_ub_n=~sel[1], ram_lb_n=~sel[0]. Counter decrements; at 0 -> ACK; on that last cycle read
//     captures dat_o<=ram_dq_i (full 16 bits regardless of sel; master extracts the lane).
//   ACK: all strobes high; write keeps ram_dq_oe=1 and ram_adr_o stable for data hold.
//     ack_o = (state==ACK) & cyc_i & stb_i; high for exactly that one cycle. -> RECOVER, or IDLE if RECOVERY=0.
//   RECOVER: strobes high, ram_dq_oe=0, RECOVERY cycles -> IDLE. A request held by the master waits.
//   Latency: request sampled in IDLE at cycle 0 -> ACCESS cycles 1..WAIT_CYCLES -> ack_o at WAIT_CYCLES+1.
//     Back-to-back request period = WAIT_CYCLES + 2 + RECOVERY cycles.
//   cyc_i/stb_i dropped mid-access: RAM access still completes (never aborted), ack_o stays 0, no retry.
//   Inputs ignored outside IDLE; ram_adr_o/ram_dq_o change only on IDLE->ACCESS, never while a strobe is low.
//   ram_oe_n and ram_we_n never low simultaneously; ram_dq_oe never 1 while ram_oe_n=0.
// TESTING (WAIT_CYCLES=4, RECOVERY=1)
//   Word read: RAM model word 0x0010=16'h1234, adr_i=15'h0010, sel=11 -> ce_n/oe_n low cycles 1-4,
//     ack_o high only cycle 5, dat_o=16'h1234, ram_adr_o=23'h000010.
//   High-byte write: adr 0x0020, sel=10, dat_i=16'hAB00, old word 16'h5566 -> ub_n=0, lb_n=1, we_n low
//     4 cycles, dq_oe high through ACK; word reads back 16'hAB66.
//   Back-to-back: master keeps cyc high, new read issued after ack -> second ack 7 cycles after first,
//     ce_n high for >=2 cycles between accesses, exactly 2 acks total.
//   sel=00 write: -> ack_o at cycle 1, ce_n/we_n never low, RAM unchanged.
//   res_i high during ACCESS cycle 2 of a write -> next edge all *_n=1, dq_oe=0, no ack; subsequent
//     read of 0x0010 still returns 16'h1234 with normal latency.
//   cyc_i dropped at ACCESS cycle 2 of a read -> strobes run to cycle 4, ack_o stays 0, back in IDLE by cycle 7.

Source files
------------

// File: rtl/wb_psram_responder_if.sv
// wb_psram_responder_if: Wishbone B3 classic bus between the CPU master and the PSRAM responder
interface wb_psram_responder_if;
   logic        cyc_i;
   logic        stb_i;
   logic        we_i;
   logic [1:0]  sel_i;
   logic [15:1] adr_i;
   logic [15:0] dat_i;
   logic        ack_o;
   logic [15:0] dat_o;
   modport master (output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, input ack_o, dat_o);
   modport slave (input cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, output ack_o, dat_o);
endinterface

// File: rtl/wb_psram_responder.sv
// wb_psram_responder: Wishbone classic responder driving an asynchronous PSRAM with timed strobes
module wb_psram_responder #(
   parameter int unsigned WAIT_CYCLES = 4,
   parameter int unsigned RECOVERY    = 1,
   parameter logic [7:0]  BANK        = 8'h00
) (
   input  logic                        clk_i,
   input  logic                        res_i,
   wb_psram_responder_if.slave         bus,
   output logic [23:1]                 ram_adr_o,
   input  logic [15:0]                 ram_dq_i,
   output logic [15:0]                 ram_dq_o,
   output logic                        ram_dq_oe,
   output logic                        ram_ce_n,
   output logic                        ram_oe_n,
   output logic                        ram_we_n,
   output logic                        ram_ub_n,
   output logic                        ram_lb_n
);
   // one counter serves both the strobe window and the recovery gap
   localparam int unsigned CMAX = (WAIT_CYCLES > RECOVERY) ? WAIT_CYCLES : RECOVERY;
   localparam int unsigned CW = (CMAX > 1) ? $clog2(CMAX) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, ACK, RECOVER} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          we_q;

   assign bus.ack_o = (state == ACK) & bus.cyc_i & bus.stb_i;

   // access sequencer: all pin strobes are registered so the pads never glitch
   always_ff @(posedge clk_i) begin
      if (res_i) begin
         state     <= IDLE;
         cnt       <= '0;
         we_q      <= 1'b0;
         bus.dat_o <= '0;
         ram_adr_o <= '0;
         ram_dq_o  <= '0;
         ram_dq_oe <= 1'b0;
         ram_ce_n  <= 1'b1;
         ram_oe_n  <= 1'b1;
         ram_we_n  <= 1'b1;
         ram_ub_n  <= 1'b1;
         ram_lb_n  <= 1'b1;
      end else begin
         case (state)
            IDLE: if (bus.cyc_i && bus.stb_i) begin
               we_q <= bus.we_i;
               if (bus.sel_i == 2'b00) begin
                  state     <= ACK;
                  bus.dat_o <= '0;
               end else begin
                  state     <= ACCESS;
                  cnt       <= CW'(WAIT_CYCLES - 1);
                  ram_adr_o <= {BANK, bus.adr_i};
                  ram_dq_o  <= bus.dat_i;
                  ram_dq_oe <= bus.we_i;
                  ram_ce_n  <= 1'b0;
                  ram_oe_n  <= bus.we_i;
                  ram_we_n  <= ~bus.we_i;
                  ram_ub_n  <= ~bus.sel_i[1];
                  ram_lb_n  <= ~bus.sel_i[0];
               end
            end
            ACCESS: if (cnt == '0) begin
               state    <= ACK;
               ram_ce_n <= 1'b1;
               ram_oe_n <= 1'b1;
               ram_we_n <= 1'b1;
               ram_ub_n <= 1'b1;
               ram_lb_n <= 1'b1;
               if (!we_q) bus.dat_o <= ram_dq_i;
            end else begin
               cnt <= cnt - 1'b1;
            end
            ACK: begin
               state     <= (RECOVERY == 0) ? IDLE : RECOVER;
               cnt       <= CW'((RECOVERY > 0) ? RECOVERY - 1 : 0);
               ram_dq_oe <= 1'b0;
            end
            RECOVER: if (cnt == '0) state <= IDLE;
                     else cnt <= cnt - 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_psram_responder.sv
// tb_wb_psram_responder: directed scoreboard bench for the Wishbone PSRAM responder
module tb_wb_psram_responder;
   logic        clk_i = 1'b0;
   logic        res_i;
   logic        init_mem;
   logic [23:1] ram_adr_o;
   logic [15:0] ram_dq_i, ram_dq_o;
   logic        ram_dq_oe, ram_ce_n, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n;
   logic [15:0] mem [0:255];
   logic [15:0] q [$];
   logic [15:0] m_ce, m_oe, m_we, m_ub, m_lb, m_dqoe, m_ack;
   int          cyc_n, checks, errors, lat, acks;

   wb_psram_responder_if bus ();

   wb_psram_responder dut (
      .clk_i(clk_i), .res_i(res_i), .bus(bus), .ram_adr_o(ram_adr_o), .ram_dq_i(ram_dq_i),
      .ram_dq_o(ram_dq_o), .ram_dq_oe(ram_dq_oe), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
      .ram_we_n(ram_we_n), .ram_ub_n(ram_ub_n), .ram_lb_n(ram_lb_n)
   );

   always #5 clk_i = ~clk_i;

   assign ram_dq_i = (!ram_ce_n && !ram_oe_n) ? mem[ram_adr_o[8:1]] : 16'hDEAD;

   // asynchronous PSRAM model: byte-lane writes while CE and WE are low
   always @(posedge clk_i) begin
      if (init_mem) begin
         mem[8'h10] <= 16'h1234;
         mem[8'h20] <= 16'h5566;
         mem[8'h30] <= 16'h9999;
      end else if (!ram_ce_n && !ram_we_n) begin
         if (!ram_ub_n) mem[ram_adr_o[8:1]][15:8] <= ram_dq_o[15:8];
         if (!ram_lb_n) mem[ram_adr_o[8:1]][7:0] <= ram_dq_o[7:0];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      cyc_n++;
      if (cyc_n < 16) begin
         m_ce[cyc_n]   = ~ram_ce_n;
         m_oe[cyc_n]   = ~ram_oe_n;
         m_we[cyc_n]   = ~ram_we_n;
         m_ub[cyc_n]   = ~ram_ub_n;
         m_lb[cyc_n]   = ~ram_lb_n;
         m_dqoe[cyc_n] = ram_dq_oe;
         m_ack[cyc_n]  = bus.ack_o;
      end
      chk("oe_we_excl", 64'(ram_oe_n | ram_we_n), 64'd1);
      chk("dqoe_vs_oe", 64'(!(ram_dq_oe && !ram_oe_n)), 64'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic start(input logic we, input logic [1:0] sel, input logic [15:1] adr, input logic [15:0] dat);
      cyc_n = 0;
      {m_ce, m_oe, m_we, m_ub, m_lb, m_dqoe, m_ack} = '0;
      bus.cyc_i = 1'b1;
      bus.stb_i = 1'b1;
      bus.we_i  = we;
      bus.sel_i = sel;
      bus.adr_i = adr;
      bus.dat_i = dat;
   endtask

   task automatic drop();
      bus.cyc_i = 1'b0;
      bus.stb_i = 1'b0;
      bus.we_i  = 1'b0;
      bus.sel_i = 2'b00;
      bus.adr_i = '0;
      bus.dat_i = '0;
   endtask

   task automatic pop_chk();
      if (q.size() > 0) chk("rd_data", 64'(bus.dat_o), 64'(q.pop_front()));
      else chk("sb_underflow", 64'(q.size()), 64'd1);
   endtask

   task automatic run(output int l);
      l = 0;
      for (int i = 0; i < 20 && l == 0; i++) begin
         tick();
         if (bus.ack_o) begin
            l = cyc_n;
            if (!bus.we_i) pop_chk();
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc_n = 0;
      res_i = 1'b1;
      init_mem = 1'b1;
      drop();
      idle(2);
      chk("reset_state",
          64'({bus.ack_o, bus.dat_o, ram_adr_o, ram_dq_o, ram_dq_oe, ram_ce_n, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n}),
          64'({1'b0, 16'h0, 23'h0, 16'h0, 1'b0, 5'b11111}));
      res_i = 1'b0;
      init_mem = 1'b0;
      idle(1);

      start(1'b0, 2'b11, 15'h0010, 16'h0);
      q.push_back(16'h1234);
      run(lat);
      chk("rd_lat", 64'(lat), 64'd5);
      chk("rd_adr", 64'(ram_adr_o), 64'h10);
      drop();
      idle(2);
      chk("rd_ce_mask", 64'(m_ce), 64'h1E);
      chk("rd_oe_mask", 64'(m_oe), 64'h1E);
      chk("rd_we_mask", 64'(m_we), 64'h0);
      chk("rd_ack_mask", 64'(m_ack), 64'h20);

      start(1'b1, 2'b10, 15'h0020, 16'hAB00);
      run(lat);
      chk("wr_lat", 64'(lat), 64'd5);
      chk("wr_dq", 64'(ram_dq_o), 64'hAB00);
      drop();
      idle(2);
      chk("wr_ce_mask", 64'(m_ce), 64'h1E);
      chk("wr_we_mask", 64'(m_we), 64'h1E);
      chk("wr_oe_mask", 64'(m_oe), 64'h0);
      chk("wr_ub_mask", 64'(m_ub), 64'h1E);
      chk("wr_lb_mask", 64'(m_lb), 64'h0);
      chk("wr_dqoe_mask", 64'(m_dqoe), 64'h3E);
      start(1'b0, 2'b11, 15'h0020, 16'h0);
      q.push_back(16'hAB66);
      run(lat);
      chk("rb_lat", 64'(lat), 64'd5);
      drop();
      idle(2);

      start(1'b0, 2'b11, 15'h0010, 16'h0);
      q.push_back(16'h1234);
      q.push_back(16'hAB66);
      acks = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bus.ack_o) begin
            acks++;
            pop_chk();
            if (acks == 1) bus.adr_i = 15'h0020;
            else drop();
         end
      end
      chk("b2b_acks", 64'(acks), 64'd2);
      chk("b2b_ack_mask", 64'(m_ack), 64'h1020);
      chk("b2b_ce_mask", 64'(m_ce), 64'h0F1E);

      start(1'b1, 2'b00, 15'h0010, 16'hFFFF);
      run(lat);
      chk("sel0_lat", 64'(lat), 64'd1);
      chk("sel0_dat", 64'(bus.dat_o), 64'h0);
      drop();
      idle(2);
      chk("sel0_ce_mask", 64'(m_ce), 64'h0);
      chk("sel0_we_mask", 64'(m_we), 64'h0);
      start(1'b0, 2'b11, 15'h0010, 16'h0);
      q.push_back(16'h1234);
      run(lat);
      chk("sel0_rb_lat", 64'(lat), 64'd5);
      drop();
      idle(2);

      start(1'b1, 2'b11, 15'h0030, 16'h0F0F);
      idle(2);
      res_i = 1'b1;
      drop();
      idle(1);
      chk("rst_mid_pins", 64'({bus.ack_o, ram_ce_n, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n, ram_dq_oe}),
          64'({1'b0, 5'b11111, 1'b0}));
      res_i = 1'b0;
      idle(1);
      start(1'b0, 2'b11, 15'h0010, 16'h0);
      q.push_back(16'h1234);
      run(lat);
      chk("rst_rd_lat", 64'(lat), 64'd5);
      drop();
      idle(2);

      start(1'b0, 2'b11, 15'h0010, 16'h0);
      idle(2);
      drop();
      idle(5);
      chk("abort_ce_mask", 64'(m_ce), 64'h1E);
      chk("abort_oe_mask", 64'(m_oe), 64'h1E);
      chk("abort_ack_mask", 64'(m_ack), 64'h0);
      start(1'b0, 2'b11, 15'h0020, 16'h0);
      q.push_back(16'hAB66);
      run(lat);
      chk("abort_next_lat", 64'(lat), 64'd5);
      drop();
      idle(2);

      chk("sb_drain", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
